mod_n_bcd_counter: RTL and testbench

//  Synchronous, parametrised multi-digit modulo-N counter (decade by default).

---
 rtl/mod_n_bcd_counter.sv | 114 +++++++++++
 tb/tb_mod_n_bcd_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_bcd_counter.sv
// mod_n_bcd_counter: multi-digit modulo-N up/down counter with synchronous
// parallel load, count enable and cascade carry/borrow.
// Optional build macro MOD_CNT_SAT_EN: saturate at the terminal state
// instead of wrapping around (load still overrides).
module mod_n_bcd_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  localparam int DW     = $clog2(MODULUS)
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] d,
  output logic [DIGITS*DW-1:0] q,
  output logic                 tc,
  output logic                 co
);

  localparam int            QW      = DIGITS * DW;
  localparam logic [DW-1:0] DIG_MAX = DW'(MODULUS - 1);

  logic [QW-1:0] r_q;
  logic [QW-1:0] w_q_nxt;
  logic [QW-1:0] w_load_val;
  logic [QW-1:0] w_step_val;
  logic          w_all_max;
  logic          w_all_zero;
  logic          w_tc;
  logic          w_hold_sat;

  // A digit code outside 0..MODULUS-1 (only reachable via load data or upset)
  function automatic logic dig_illegal(input logic [DW-1:0] v);
    return (32'(v) >= MODULUS);
  endfunction

  // Load value with every out-of-range digit replaced by 0
  always_comb begin
    w_load_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!dig_illegal(d[i*DW +: DW])) begin
        w_load_val[i*DW +: DW] = d[i*DW +: DW];
      end
    end
  end

  // Exact terminal-state detection over all digits
  always_comb begin
    w_all_max  = 1'b1;
    w_all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_q[i*DW +: DW] != DIG_MAX) w_all_max = 1'b0;
      if (r_q[i*DW +: DW] != '0)      w_all_zero = 1'b0;
    end
  end

  // One up/down step: a digit moves only when every lower digit is terminal.
  // Illegal digit codes count as terminal so they wrap back into range.
  always_comb begin : p_step
    logic          w_prop;
    logic          w_term;
    logic [DW-1:0] w_dig;
    w_step_val = r_q;
    w_prop     = 1'b1;
    w_term     = 1'b0;
    w_dig      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig = r_q[i*DW +: DW];
      if (up_dn) begin
        w_term = (w_dig >= DIG_MAX);
        if (w_prop) w_step_val[i*DW +: DW] = w_term ? '0 : w_dig + 1'b1;
      end else begin
        w_term = (w_dig == '0) || dig_illegal(w_dig);
        if (w_prop) w_step_val[i*DW +: DW] = w_term ? DIG_MAX : w_dig - 1'b1;
      end
      w_prop = w_prop & w_term;
    end
  end

  // Terminal count depends only on the held value and the current direction
  assign w_tc = up_dn ? w_all_max : w_all_zero;

`ifdef MOD_CNT_SAT_EN
  assign w_hold_sat = w_tc;
`else
  assign w_hold_sat = 1'b0;
`endif

  // Next-value select: load > enabled step > hold
  always_comb begin
    if (load) begin
      w_q_nxt = w_load_val;
    end else if (en && !w_hold_sat) begin
      w_q_nxt = w_step_val;
    end else begin
      w_q_nxt = r_q;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign q  = r_q;
  assign tc = w_tc;
  assign co = w_tc & en & ~load;

endmodule

// File: tb/tb_mod_n_bcd_counter.sv
// Self-checking bench for mod_n_bcd_counter (2-digit decade main instance,
// a two-instance cascade and a single-digit modulo-6 instance).
module tb_mod_n_bcd_counter;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_tc;
    logic       exp_co;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       res_n;
  logic       en, up_dn, load;
  logic [7:0] d;
  logic [7:0] q;
  logic       tc, co;

  logic       c_en, c_up, c_load;
  logic [7:0] c_d;
  logic [7:0] ca_q, cb_q;
  logic       ca_tc, ca_co, cb_tc, cb_co;

  logic       m_en, m_up, m_load;
  logic [2:0] m_d;
  logic [2:0] m_q;
  logic       m_tc, m_co;

  int         errs = 0;
  int         checks = 0;
  int         model_v = 0;
  logic [7:0] exp_fifo[$];
  vec_t       tbl[10];

  always #5 clk = ~clk;

  mod_n_bcd_counter #(.DIGITS(2), .MODULUS(10)) dut (
    .clk(clk), .res_n(res_n), .en(en), .up_dn(up_dn), .load(load),
    .d(d), .q(q), .tc(tc), .co(co));

  mod_n_bcd_counter #(.DIGITS(2), .MODULUS(10)) cas_a (
    .clk(clk), .res_n(res_n), .en(c_en), .up_dn(c_up), .load(c_load),
    .d(c_d), .q(ca_q), .tc(ca_tc), .co(ca_co));

  mod_n_bcd_counter #(.DIGITS(2), .MODULUS(10)) cas_b (
    .clk(clk), .res_n(res_n), .en(ca_co), .up_dn(c_up), .load(c_load),
    .d(c_d), .q(cb_q), .tc(cb_tc), .co(cb_co));

  mod_n_bcd_counter #(.DIGITS(1), .MODULUS(6)) dut6 (
    .clk(clk), .res_n(res_n), .en(m_en), .up_dn(m_up), .load(m_load),
    .d(m_d), .q(m_q), .tc(m_tc), .co(m_co));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic u, input logic l,
                              input logic [7:0] dv, input logic [7:0] eq,
                              input logic et, input logic ec, input string nm);
    vec_t v;
    v.en = e; v.up = u; v.load = l; v.d = dv;
    v.exp_q = eq; v.exp_tc = et; v.exp_co = ec; v.name = nm;
    return v;
  endfunction

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int load2int(input logic [7:0] b);
    int hi, lo;
    hi = (b[7:4] > 4'd9) ? 0 : int'(b[7:4]);
    lo = (b[3:0] > 4'd9) ? 0 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic int nxt(input int v, input bit e, input bit u, input int total);
    if (!e) return v;
    if (u) begin
      if (v == total - 1) begin
`ifdef MOD_CNT_SAT_EN
        return v;
`else
        return 0;
`endif
      end
      return v + 1;
    end
    if (v == 0) begin
`ifdef MOD_CNT_SAT_EN
      return 0;
`else
      return total - 1;
`endif
    end
    return v - 1;
  endfunction

  function automatic bit tc_of(input int v, input bit u, input int total);
    return u ? (v == total - 1) : (v == 0);
  endfunction

  task automatic step_vec(input vec_t v);
    logic [7:0] e;
    en = v.en; up_dn = v.up; load = v.load; d = v.d;
    @(negedge clk);
    chk({v.name, " tc"}, 32'(tc), 32'(v.exp_tc));
    chk({v.name, " co"}, 32'(co), 32'(v.exp_co));
    exp_fifo.push_back(v.exp_q);
    @(posedge clk);
    #1;
    e = exp_fifo.pop_front();
    chk({v.name, " q"}, 32'(q), 32'(e));
    model_v = bcd2int(e);
  endtask

  task automatic step_model(input logic e, input logic u, input logic l,
                            input logic [7:0] dv, input string nm);
    vec_t v;
    int   nv;
    nv = l ? load2int(dv) : nxt(model_v, e, u, 100);
    v = mk(e, u, l, dv, int2bcd(nv), tc_of(model_v, u, 100),
           tc_of(model_v, u, 100) & e & ~l, nm);
    step_vec(v);
  endtask

  initial begin
    int a, b, a_pre, mv;

    tbl[0] = mk(1'b0, 1'b1, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0, "ld99");
    tbl[1] = mk(1'b1, 1'b1, 1'b1, 8'h4C, 8'h40, 1'b1, 1'b0, "ld4C_prio");
    tbl[2] = mk(1'b1, 1'b1, 1'b0, 8'h00, 8'h41, 1'b0, 1'b0, "up40");
    tbl[3] = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, "dn41");
    tbl[4] = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h39, 1'b0, 1'b0, "dn40_borrow");
    tbl[5] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h39, 1'b0, 1'b0, "hold39");
    tbl[6] = mk(1'b0, 1'b0, 1'b1, 8'hC5, 8'h05, 1'b0, 1'b0, "ldC5");
    tbl[7] = mk(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, "ldFF");
    tbl[8] = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, "tc_no_en");
`ifdef MOD_CNT_SAT_EN
    tbl[9] = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, "dn_sat");
`else
    tbl[9] = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1, "dn_wrap");
`endif

    res_n = 1'b0;
    en = 1'b0; up_dn = 1'b1; load = 1'b0; d = 8'h00;
    c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_d = 8'h00;
    m_en = 1'b0; m_up = 1'b1; m_load = 1'b0; m_d = 3'd0;
    #12;
    chk("reset q", 32'(q), 32'h0);
    chk("reset tc", 32'(tc), 32'h0);
    @(negedge clk);
    res_n = 1'b1;
    @(posedge clk);
    #1;
    model_v = 0;

    for (int i = 0; i < 10; i++) step_vec(tbl[i]);

    step_model(1'b0, 1'b1, 1'b1, 8'h00, "ld00");
    for (int i = 0; i < 100; i++) step_model(1'b1, 1'b1, 1'b0, 8'h00, "up100");

    step_model(1'b0, 1'b0, 1'b1, 8'h10, "ld10");
    for (int i = 0; i < 11; i++) step_model(1'b1, 1'b0, 1'b0, 8'h00, "dn10");

    step_model(1'b0, 1'b1, 1'b1, 8'h98, "ld98");
    for (int i = 0; i < 3; i++) step_model(1'b1, 1'b1, 1'b0, 8'h00, "up98");
    step_model(1'b1, 1'b0, 1'b0, 8'h00, "turn_dn");

    step_model(1'b0, 1'b1, 1'b1, 8'h37, "ld37");
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    @(negedge clk);
    #2;
    res_n = 1'b0;
    #1;
    chk("rst_async q", 32'(q), 32'h0);
    chk("rst_async tc", 32'(tc), 32'h0);
    load = 1'b1; d = 8'h55;
    @(posedge clk);
    #1;
    chk("rst_load_discard q", 32'(q), 32'h0);
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    res_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release q", 32'(q), 32'h0);
    model_v = 0;

    a = 0; b = 0;
    c_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      chk("casA co", 32'(ca_co), 32'(tc_of(a, 1'b1, 100)));
      @(posedge clk);
      #1;
      a_pre = a;
      a = nxt(a, 1'b1, 1'b1, 100);
      if (tc_of(a_pre, 1'b1, 100)) b = nxt(b, 1'b1, 1'b1, 100);
      chk("casA q", 32'(ca_q), 32'(int2bcd(a)));
      chk("casB q", 32'(cb_q), 32'(int2bcd(b)));
    end
    c_en = 1'b0;

    mv = 0;
    m_en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      m_up = (i < 14);
      @(negedge clk);
      chk("mod6 tc", 32'(m_tc), 32'(tc_of(mv, m_up, 6)));
      @(posedge clk);
      #1;
      mv = nxt(mv, 1'b1, m_up, 6);
      chk("mod6 q", 32'(m_q), 32'(mv));
    end
    m_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
